// File: rtl/hud_status_tracker.sv
// hud_status_tracker
//   Game-state block feeding the HUD text renderer. Tracks hearts (0..MAX_HEALTH),
//   a two-digit BCD gem score saturating at SCORE_MAX, and a post-hit
//   invulnerability window measured in frame_tick pulses.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous active-high reset
//   frame_tick    in   one pulse per video frame
//   new_game      in   restart pulse, overrides every other input
//   gem_collected in   adds 1 to the BCD score
//   player_hit    in   damage request
//   heal          in   restore one heart
//   score1        out  BCD ones digit
//   score2        out  BCD tens digit
//   health        out  current hearts
//   invincible    out  high while in INVULN
//   game_over     out  high while in DEAD
//   state_dbg     out  current FSM state (PLAYING=0, INVULN=1, DEAD=2)
//
// Event inputs are single-cycle pulses with no handshake: each pulse present at a
// rising edge is one event, and its effect is visible on the outputs after that edge.
module hud_status_tracker #(
  parameter int unsigned MAX_HEALTH    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned SCORE_MAX     = 99
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       new_game,
  input  logic       gem_collected,
  input  logic       player_hit,
  input  logic       heal,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] health,
  output logic       invincible,
  output logic       game_over,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_INVULN  = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  localparam logic [1:0] MAX_H     = 2'(MAX_HEALTH);
  localparam logic [7:0] WIN_LOAD  = 8'(INVULN_FRAMES);
  localparam logic [6:0] SCORE_SAT = 7'(SCORE_MAX);

  state_t     state_q, state_d;
  logic [1:0] health_q, health_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [7:0] cnt_q, cnt_d;
  logic       invincible_q, invincible_d;
  logic       game_over_q, game_over_d;
  logic [6:0] score_val;

  // Decimal value of the BCD pair, used only for the saturation compare.
  assign score_val = ({3'b000, score2_q} * 7'd10) + {3'b000, score1_q};

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;

    if (new_game) begin
      state_d  = ST_PLAYING;
      health_d = MAX_H;
      score1_d = 4'd0;
      score2_d = 4'd0;
      cnt_d    = 8'd0;
    end else begin
      case (state_q)
        ST_PLAYING: begin
          // A hit wins over a heal; a coincident frame_tick is not applied to
          // the freshly loaded window.
          if (player_hit) begin
            if (health_q > 2'd1) begin
              health_d = health_q - 2'd1;
              cnt_d    = WIN_LOAD;
              state_d  = ST_INVULN;
            end else begin
              health_d = 2'd0;
              state_d  = ST_DEAD;
            end
          end else if (heal && (health_q < MAX_H)) begin
            health_d = health_q + 2'd1;
          end
        end
        ST_INVULN: begin
          // Hits are ignored here, so a coincident heal always applies.
          if (heal && (health_q < MAX_H)) begin
            health_d = health_q + 2'd1;
          end
          if (frame_tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = ST_PLAYING;
            end
          end
        end
        ST_DEAD: begin
          health_d = 2'd0;
        end
        default: begin
          state_d = ST_PLAYING;
        end
      endcase

      // Score uses the current state, so a gem alongside a fatal hit still counts.
      if ((state_q != ST_DEAD) && gem_collected && (score_val != SCORE_SAT)) begin
        if (score1_q >= 4'd9) begin
          score1_d = 4'd0;
          score2_d = score2_q + 4'd1;
        end else begin
          score1_d = score1_q + 4'd1;
        end
      end
    end

    invincible_d = (state_d == ST_INVULN);
    game_over_d  = (state_d == ST_DEAD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_PLAYING;
      health_q     <= MAX_H;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      cnt_q        <= 8'd0;
      invincible_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      health_q     <= health_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      cnt_q        <= cnt_d;
      invincible_q <= invincible_d;
      game_over_q  <= game_over_d;
    end
  end

  assign score1     = score1_q;
  assign score2     = score2_q;
  assign health     = health_q;
  assign invincible = invincible_q;
  assign game_over  = game_over_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hud_status_tracker.sv
module tb_hud_status_tracker;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] I = 2'd1;
  localparam logic [1:0] D = 2'd2;

  // Event vector order: {new_game, gem_collected, player_hit, heal, frame_tick}
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_NG   = 5'b10000;
  localparam logic [4:0] EV_GEM  = 5'b01000;
  localparam logic [4:0] EV_HIT  = 5'b00100;
  localparam logic [4:0] EV_HEAL = 5'b00010;
  localparam logic [4:0] EV_TICK = 5'b00001;

  localparam int W = 14;

  logic       Clk;
  logic       Reset;
  logic       frame_tick, new_game, gem_collected, player_hit, heal;
  logic [3:0] score1, score2;
  logic [1:0] health;
  logic       invincible, game_over;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           failures;
  string        phase;

  hud_status_tracker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .new_game     (new_game),
    .gem_collected(gem_collected),
    .player_hit   (player_hit),
    .heal         (heal),
    .score1       (score1),
    .score2       (score2),
    .health       (health),
    .invincible   (invincible),
    .game_over    (game_over),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard compare ----------------
  task automatic compare(input string name, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = {score2, score1, health, invincible, game_over, state_dbg};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got s=%0d%0d h=%0d inv=%0b go=%0b st=%0d, exp s=%0d%0d h=%0d inv=%0b go=%0b st=%0d",
               name, got[13:10], got[9:6], got[5:4], got[3], got[2], got[1:0],
               exp[13:10], exp[9:6], exp[5:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  function automatic logic [W-1:0] pack(input int sc, input int h, input logic inv,
                                        input logic go, input logic [1:0] st);
    return {4'(sc / 10), 4'(sc % 10), 2'(h), inv, go, st};
  endfunction

  // ---------------- monitor ----------------
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      compare(phase, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle of events and queues the outputs expected after the next edge.
  task automatic cyc(input logic [4:0] ev, input int sc, input int h,
                     input logic inv, input logic go, input logic [1:0] st);
    @(negedge Clk);
    {new_game, gem_collected, player_hit, heal, frame_tick} = ev;
    exp_q.push_back(pack(sc, h, inv, go, st));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge Clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    phase = "reset";
    Reset = 1'b1;
    {new_game, gem_collected, player_hit, heal, frame_tick} = EV_NONE;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1 compare("reset_values", pack(0, 3, 0, 0, P));

    // 1: twelve gems -> 12
    phase = "gems_12";
    for (int i = 0; i < 12; i++) cyc(EV_GEM, i + 1, 3, 0, 0, P);

    // 2: up to 98, then three more saturate at 99
    phase = "gems_to_98";
    for (int i = 12; i < 98; i++) cyc(EV_GEM, i + 1, 3, 0, 0, P);
    phase = "score_saturate";
    for (int i = 0; i < 3; i++) cyc(EV_GEM, 99, 3, 0, 0, P);
    phase = "new_game_1";
    cyc(EV_NG, 0, 3, 0, 0, P);

    // 3: hit, ignored second hit, 60-tick window
    phase = "first_hit";
    cyc(EV_HIT, 0, 2, 1, 0, I);
    for (int i = 0; i < 4; i++) cyc(EV_NONE, 0, 2, 1, 0, I);
    phase = "hit_ignored_invuln";
    cyc(EV_HIT, 0, 2, 1, 0, I);
    phase = "window_59_ticks";
    for (int i = 0; i < 59; i++) cyc(EV_TICK, 0, 2, 1, 0, I);
    phase = "window_60th_tick";
    cyc(EV_TICK, 0, 2, 0, 0, P);
    phase = "tick_in_playing";
    cyc(EV_TICK, 0, 2, 0, 0, P);
    phase = "second_hit";
    cyc(EV_HIT, 0, 1, 1, 0, I);

    // 4: elapse window, fatal hit with gem, dead is frozen, new game
    phase = "window_2";
    for (int i = 0; i < 59; i++) cyc(EV_TICK, 0, 1, 1, 0, I);
    cyc(EV_TICK, 0, 1, 0, 0, P);
    phase = "fatal_hit_with_gem";
    cyc(EV_HIT | EV_GEM, 1, 0, 0, 1, D);
    phase = "dead_frozen";
    cyc(EV_GEM, 1, 0, 0, 1, D);
    cyc(EV_HEAL, 1, 0, 0, 1, D);
    cyc(EV_HIT, 1, 0, 0, 1, D);
    cyc(EV_TICK, 1, 0, 0, 1, D);
    cyc(EV_GEM | EV_HEAL | EV_TICK, 1, 0, 0, 1, D);
    phase = "new_game_from_dead";
    cyc(EV_NG | EV_HIT | EV_GEM, 0, 3, 0, 0, P);

    // 5: simultaneous events
    phase = "setup_health2";
    cyc(EV_HIT, 0, 2, 1, 0, I);
    for (int i = 0; i < 59; i++) cyc(EV_TICK, 0, 2, 1, 0, I);
    cyc(EV_TICK, 0, 2, 0, 0, P);
    phase = "heal_hit_playing";
    cyc(EV_HEAL | EV_HIT, 0, 1, 1, 0, I);
    cyc(EV_TICK, 0, 1, 1, 0, I);
    phase = "heal_hit_invuln";
    cyc(EV_HEAL | EV_HIT, 0, 2, 1, 0, I);
    phase = "gem_heal_invuln";
    cyc(EV_GEM | EV_HEAL | EV_TICK, 1, 3, 1, 0, I);
    phase = "window_after_heal";
    for (int i = 0; i < 57; i++) cyc(EV_TICK, 1, 3, 1, 0, I);
    cyc(EV_TICK, 1, 3, 0, 0, P);
    phase = "heal_at_max";
    cyc(EV_HEAL, 1, 3, 0, 0, P);
    phase = "tick_with_hit";
    cyc(EV_TICK | EV_HIT, 1, 2, 1, 0, I);
    for (int i = 0; i < 59; i++) cyc(EV_TICK, 1, 2, 1, 0, I);
    phase = "tick_with_hit_end";
    cyc(EV_TICK, 1, 2, 0, 0, P);
    phase = "heal_playing";
    cyc(EV_HEAL, 1, 3, 0, 0, P);
    phase = "new_game_over_heal";
    cyc(EV_NG | EV_HEAL, 0, 3, 0, 0, P);

    // 6: asynchronous reset mid-window at score 47
    phase = "gems_to_47";
    for (int i = 0; i < 47; i++) cyc(EV_GEM, i + 1, 3, 0, 0, P);
    phase = "hit_before_reset";
    cyc(EV_HIT, 47, 2, 1, 0, I);
    for (int i = 0; i < 5; i++) cyc(EV_TICK, 47, 2, 1, 0, I);
    cyc(EV_NONE, 47, 2, 1, 0, I);
    drain();
    #1 Reset = 1'b1;
    #1 compare("async_reset_immediate", pack(0, 3, 0, 0, P));
    repeat (2) @(posedge Clk);
    #1 compare("reset_held", pack(0, 3, 0, 0, P));
    @(negedge Clk);
    Reset = 1'b0;
    phase = "after_release_tick";
    cyc(EV_TICK, 0, 3, 0, 0, P);
    phase = "after_release_gem";
    cyc(EV_GEM, 1, 3, 0, 0, P);
    phase = "after_release_hit";
    cyc(EV_HIT, 1, 2, 1, 0, I);
    cyc(EV_NONE, 1, 2, 1, 0, I);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hud_status_tracker.md
Name: hud_status_tracker

Overview:
Sequential game-state block directly upstream of the HUD text renderer. Tracks player health (0..3 hearts) and a two-digit BCD gem score, and runs a post-hit invulnerability window timed in video frames. Outputs are registered and feed the renderer's score1/score2/health inputs directly, plus game-over and invulnerability status for the sprite and game logic.

Parameters:
MAX_HEALTH, 3, health value after reset or new game; also the heal ceiling; legal range 1..3
INVULN_FRAMES, 60, number of frame_tick pulses in the post-hit invulnerability window; legal range 1..255
SCORE_MAX, 99, decimal score saturation value; legal range 1..99

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-Clk pulse per video frame (vsync-derived)
new_game  input  1  one-Clk pulse; restarts the game
gem_collected  input  1  one-Clk pulse; adds 1 to the score
player_hit  input  1  one-Clk pulse; damage request
heal  input  1  one-Clk pulse; restores 1 heart
score1  output  4  BCD ones digit, 0..9
score2  output  4  BCD tens digit, 0..9
health  output  2  current hearts, 0..MAX_HEALTH
invincible  output  1  high while in INVULN
game_over  output  1  high while in DEAD

Behaviour:
- Reset (asynchronous, any time, including mid-window):
  - state=PLAYING, health=MAX_HEALTH, score1=0, score2=0.
  - invincible=0, game_over=0, frame counter=0.
- All outputs are registered. An event pulse at edge N is visible after edge N (1-cycle latency).
- States: PLAYING, INVULN, DEAD.
- PLAYING, on player_hit:
  - If health>1: health-=1, counter=INVULN_FRAMES, go to INVULN.
  - If health==1: health=0, go to DEAD.
- INVULN:
  - player_hit is ignored.
  - Each frame_tick decrements the counter.
  - A frame_tick arriving when counter==1: counter becomes 0, go to PLAYING on the same edge.
  - Counter never wraps below 0.
  - invincible=1 throughout INVULN.
- DEAD:
  - game_over=1, health=0.
  - gem_collected, heal, player_hit and frame_tick are all ignored.
  - Score is frozen for display.
- new_game, in any state: same values as reset, applied synchronously. It has top priority over every other input in that cycle.
- Score:
  - gem_collected in PLAYING or INVULN does a BCD increment.
  - If score1==9: score1=0 and score2+=1. Otherwise score1+=1.
  - Saturates: when the decimal value equals SCORE_MAX, further gems are ignored.
  - score1/score2 never hold values above 9.
- Heal: in PLAYING or INVULN, health+=1, saturating at MAX_HEALTH. Heal does not alter state or counter.
- Simultaneous events in one cycle:
  - gem_collected with player_hit: both apply. The score increments even if the hit is fatal.
  - heal with player_hit, in PLAYING: the hit applies and the heal is dropped.
  - heal with player_hit, in INVULN: the heal applies and the hit is ignored.
  - frame_tick with player_hit, in PLAYING: the hit loads counter=INVULN_FRAMES. The tick is not applied to the new window.
- Pulses wider than one Clk are treated as one event per Clk. Upstream guarantees single-cycle pulses.

Test Plan:
1. Reset, then 12 gem_collected pulses -> score2=1, score1=2, health=3, invincible=0, game_over=0.
2. From score 98, send 3 gems -> 99 after the first gem. Stays score2=9, score1=9.
3. player_hit, then another player_hit 5 cycles later with INVULN_FRAMES=60 -> health=2, invincible=1, second hit ignored. After 59 frame_ticks invincible is still 1. The 60th tick clears it. A new hit then gives health=1.
4. Three spaced hits (window elapsed between each) -> health=0, game_over=1. Gems, heal and hits afterwards change nothing. new_game -> health=3, score 00, game_over=0.
5. Simultaneous events in PLAYING with health=2:
   - heal with player_hit -> health=1, INVULN.
   - In INVULN, heal with player_hit -> health=2, counter unchanged.
   - Heal at health=3 -> stays 3.
6. Assert Reset asynchronously mid-INVULN, between clock edges, at score 47 -> outputs go immediately to health=3, score 00, invincible=0. State is PLAYING after release.
